// File: rtl/rr_arbiter4_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // One-hot to index, same code as the downstream 4-to-2 encoder; non-one-hot maps to 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping mod 4.
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter with grant locking, hold-time limit and a forced-release pulse.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               timeout
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   pick_winner;
  logic               pick_any;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d              = pick_winner;
          gnt_d                = '0;
          gnt_d[pick_winner]   = 1'b1;
          gnt_id_d             = onehot_to_idx(gnt_d);
          gnt_valid_d          = 1'b1;
          hold_cnt_d           = CNT_W'(1);
          state_d              = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Owner drop takes precedence over the hold limit, so a coincident drop never pulses timeout.
        if (!req[owner_q] || (hold_cnt_q == CNT_W'(MAX_HOLD))) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          ptr_d       = owner_q + IDX_W'(1);
          state_d     = ST_IDLE;
          timeout_d   = req[owner_q];
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter with grant locking and a hold-time limit. It sits directly upstream of the 4-to-2 one-hot encoder. Its registered one-hot grant vector is always zero or exactly one-hot, so it meets the encoder's input contract. It also outputs the equivalent 2-bit grant index, registered, for consumers that need the code without the encoder's combinational delay.

## Interface
Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one requester may hold the grant. Legal range 1..255; 0 is illegal.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  input  4  request lines; bit i = requester i. May change any cycle.
- gnt  output  4  registered grant vector; all-zero or exactly one-hot.
- gnt_valid  output  1  high iff gnt is non-zero.
- gnt_id  output  2  registered index of the granted bit: bit0->00, bit1->01, bit2->10, bit3->11. It is 00 when gnt_valid is low.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked at MAX_HOLD.

## Operation
- Two states, IDLE and GRANT. Internal registers:
  - ptr[1:0]: highest-priority index.
  - owner[1:0]: current grant holder.
  - hold_cnt[7:0].
- Reset (rst_n low at a clock edge):
  - state=IDLE, ptr=0, owner=0, hold_cnt=0.
  - gnt=0000, gnt_valid=0, gnt_id=00, timeout=0.
  - Reset wins over every other event, including mid-grant; the grant drops at that same edge.
- IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise, pick the first set bit searching from ptr, ptr+1, ... wrapping mod 4.
  - Then: owner=winner, gnt=one-hot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=1, go to GRANT.
- GRANT (checks in priority order):
  - If req[owner]==0: normal release. gnt=0, gnt_valid=0, gnt_id=00, ptr=owner+1 (mod 4), go to IDLE.
  - Else if hold_cnt==MAX_HOLD: forced release. Same updates as a normal release, plus timeout=1 for that one cycle.
  - Else: hold_cnt=hold_cnt+1; grant unchanged.
- Changes on req bits other than owner's have no effect while in GRANT.
- timeout is 0 in every cycle except the one following a forced release.
- ptr wraps 3->0. Because ptr advances past the previous owner, a requester held high continuously cannot win twice in a row while another requester is pending.

## Timing
- Grant latency: req sampled at edge k in IDLE -> gnt valid after edge k; visible from cycle k+1.
- Release latency: req[owner] sampled low at edge k -> gnt=0000 after edge k.
- There is always at least one bubble cycle with gnt=0000 between consecutive grants, including across a forced release. This guarantees that gnt never switches directly between two different one-hot values.
- Forced release: gnt stays high for exactly MAX_HOLD cycles. timeout is high in the first bubble cycle.
- gnt, gnt_valid, gnt_id and timeout are all flop outputs; no combinational path from req to any output.
- Simultaneous release and hold-limit (req[owner] drops on the MAX_HOLD cycle): treat as a normal release; timeout stays 0.

## Structure
- The shared package holds:
  - the state enum (ST_IDLE, ST_GRANT);
  - the constant NUM_REQ=4;
  - a function mapping a one-hot value to its index, using the same encoding as the downstream encoder.
- One natural sub-module, rr_pick4: a combinational rotate-priority picker. Inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and any.
- The top holds the FSM, counter and output registers.

## Test plan
- Reset then single request:
  - rst_n low for 2 cycles: all outputs 0.
  - req=0100: gnt=0100, gnt_id=10, gnt_valid=1 one cycle later.
  - Drop req: gnt=0000 next cycle; ptr now 3.
- Rotation fairness: req=1111 held with each owner dropping its bit for one cycle after 2 cycles of grant. Grant order is 0001, 0010, 0100, 1000, 0001, with one bubble between each.
- Wrap priority: after owner=3 releases, req=1001. Next grant is 0001, not 1000.
- Hold limit, MAX_HOLD=8: req=0010 held high.
  - gnt=0010 for exactly 8 cycles, then gnt=0000 with timeout=1 for one cycle.
  - Regrant: req=0011 held high through the bubble. Bit 0 must win next, since ptr=2 wraps to 0.
- Release on limit cycle: req[owner] drops on hold_cnt==MAX_HOLD. gnt=0000 next cycle, timeout stays 0.
- Mid-grant reset: rst_n low while gnt=1000 and req=1111. All outputs 0 at the next edge, ptr=0. After rst_n returns high, first grant is 0001.
- Assertion in all tests: gnt is zero or one-hot every cycle, gnt_valid equals the OR of gnt, and gnt_id matches gnt.
